im_port_arbiter: RTL and testbench
==================================

// Module: im_port_arbiter
// PURPOSE
//  Owns the single port of the synchronous instruction RAM and shares it between two requesters:
//  the CPU fetch stage (reads) and the program loader (writes code/handler images).
//  It range- and alignment-checks every fetch and returns nop plus AdEL on a bad PC.
//  It bounds loader bursts so that fetch is never starved.
//  It sits between the IF stage / loader and the 4096-word instruction RAM.
// PARAMETERS
//  AW         12           RAM word-address width (4096 words)
//  BASE       32'h0000_3000 first legal byte address
//  LIMIT      32'h0000_4FFF last legal byte address
//  EXC_ADEL   5'd4         exception code for bad fetch address
//  MAX_BURST  4            max consecutive loader grants while fetch waits
// PORTS
//  clk        in   1   clock, rising edge
//  reset_n    in   1   asynchronous reset, active low
//  f_req      in   1   fetch request (level, held until f_gnt)
//  f_addr     in   32  fetch byte address (PC)
//  f_flush    in   1   kill any fetch response not yet delivered
//  f_gnt      out  1   fetch accepted this cycle
//  f_rvalid   out  1   one-cycle pulse: f_rdata/f_exc valid
//  f_rdata    out  32  instruction word (0 = nop on exception)
//  f_exc      out  5   0, or EXC_ADEL
//  l_req      in   1   loader write request (held until l_gnt)
//  l_addr     in   32  loader byte address
//  l_wdata    in   32  loader write data
//  l_gnt      out  1   loader request accepted this cycle
//  l_err      out  1   pulses together with l_gnt if l_addr is illegal (write dropped)
//  mem_en     out  1   RAM enable
//  mem_we     out  1   RAM write enable
//  mem_addr   out  AW  RAM word address = (addr - BASE) >> 2
//  mem_wdata  out  32  RAM write data
//  mem_rdata  in   32  RAM read data, valid the cycle after mem_en && !mem_we
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0; burst_cnt=0; state IDLE; no response pending.
//  Legal address: BASE <= addr <= LIMIT and addr[1:0]==2'b00; all other addresses are illegal.
//  Grant (combinational on the current request/state signals, one grant per cycle at most):
//   - loader wins when l_req && (!f_req || burst_cnt < MAX_BURST); otherwise fetch wins if f_req.
//   - burst_cnt increments on each l_gnt while f_req=1, and clears on f_gnt or when f_req=0.
//  State machine: IDLE, RD, EXC
//   - IDLE: legal fetch granted -> mem_en=1, mem_we=0, go RD; illegal fetch granted -> no RAM
//     access, go EXC; loader granted -> stay IDLE (goes RD/EXC instead only if a fetch was granted).
//   - RD: f_rvalid=1, f_rdata=mem_rdata, f_exc=0 (one cycle after grant). A new grant may be
//     issued in the same cycle (back-to-back, throughput 1/cycle); next state follows the IDLE rules.
//   - EXC: f_rvalid=1, f_rdata=0, f_exc=EXC_ADEL; next state follows the IDLE rules.
//  Loader writes: legal -> mem_en=1, mem_we=1 in the grant cycle, no response. Illegal ->
//   l_gnt=1, l_err=1, RAM untouched.
//  f_flush=1: suppresses f_rvalid in that cycle and drops the response of any fetch granted
//   earlier. A fetch granted in the same cycle as f_flush is NOT killed.
//  f_rdata/f_exc are 0 whenever f_rvalid=0.
//  Address math is 32-bit unsigned subtract; bits [AW+1:2] are used, so no wrap is possible for
//   legal addresses.
//  reset_n asserted mid-transfer: the in-flight response is discarded and no f_rvalid is issued.
// TESTING
//  1 f_req, f_addr=0x3000, RAM[0]=0x3C010001 -> f_gnt@T, mem_addr=0, f_rvalid@T+1 with 0x3C010001, f_exc=0
//  2 f_addr=0x3002, then 0x5000, then 0x2FFC -> no mem_en; each gives f_rvalid, f_rdata=0, f_exc=4
//  3 l_req and f_req held together -> l_gnt for 4 cycles, then f_gnt, then l_gnt resumes; burst_cnt clears
//  4 loader writes 0x4180 <- 0x12345678, then fetch 0x4180 -> mem_addr=1120, we=1; fetch returns 0x12345678
//  5 fetch granted at T, f_flush@T+1 -> no f_rvalid; fetch granted at T+1 delivers at T+2
//  6 l_addr=0x4FFE -> l_gnt=l_err=1, mem_en=0; reset_n low while in RD -> outputs 0, no f_rvalid afterwards

Source files
------------

// File: rtl/im_port_arbiter.sv
// Single-port instruction RAM arbiter shared by the fetch stage (reads) and the program loader (writes).
// Range/alignment-checks every access and bounds loader bursts so fetch is never starved.
module im_port_arbiter #(
   parameter int          AW        = 12,
   parameter logic [31:0] BASE      = 32'h0000_3000,
   parameter logic [31:0] LIMIT     = 32'h0000_4FFF,
   parameter logic [4:0]  EXC_ADEL  = 5'd4,
   parameter int          MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   input  logic          f_flush,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic [4:0]    f_exc,
   input  logic          l_req,
   input  logic [31:0]   l_addr,
   input  logic [31:0]   l_wdata,
   output logic          l_gnt,
   output logic          l_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] MAX_B  = BW'(MAX_BURST);
   localparam logic [AW-1:0] BASE_W = BASE[AW+1:2];

   typedef enum logic [1:0] {IDLE, RD, EXC} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            f_legal, l_legal;

   function automatic logic is_legal(input logic [31:0] a);
      return (a >= BASE) && (a <= LIMIT) && (a[1:0] == 2'b00);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin
      f_gnt       = 1'b0;
      l_gnt       = 1'b0;
      l_err       = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      f_rvalid    = 1'b0;
      f_rdata     = '0;
      f_exc       = '0;
      state_d     = IDLE;
      burst_cnt_d = burst_cnt_q;
      f_legal     = is_legal(f_addr);
      l_legal     = is_legal(l_addr);

      // Grants are held off during reset so every output reads 0 while reset_n is low.
      if (reset_n) begin
         if (l_req && (!f_req || (burst_cnt_q < MAX_B))) begin
            l_gnt = 1'b1;
         end else if (f_req) begin
            f_gnt = 1'b1;
         end
      end

      // BASE is word aligned, so subtracting only the word-index bits gives the same result as the full subtract.
      if (l_gnt) begin
         if (l_legal) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = l_addr[AW+1:2] - BASE_W;
            mem_wdata = l_wdata;
         end else begin
            l_err = 1'b1;
         end
      end

      if (f_gnt) begin
         if (f_legal) begin
            mem_en   = 1'b1;
            mem_addr = f_addr[AW+1:2] - BASE_W;
            state_d  = RD;
         end else begin
            state_d  = EXC;
         end
      end

      if (!f_req || f_gnt) begin
         burst_cnt_d = '0;
      end else if (l_gnt) begin
         burst_cnt_d = burst_cnt_q + BW'(1);
      end

      // A flush only masks the response due now; a fetch granted this cycle still completes.
      if (!f_flush) begin
         case (state_q)
            RD: begin
               f_rvalid = 1'b1;
               f_rdata  = mem_rdata;
            end
            EXC: begin
               f_rvalid = 1'b1;
               f_exc    = EXC_ADEL;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_im_port_arbiter.sv
// Directed self-checking bench for im_port_arbiter with a behavioural 4096-word synchronous RAM.
module tb_im_port_arbiter;

   logic        clk;
   logic        reset_n;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_flush;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic [4:0]  f_exc;
   logic        l_req;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_err;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] ram [0:4095];

   int checkCount;
   int errorCount;

   im_port_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .f_req     (f_req),
      .f_addr    (f_addr),
      .f_flush   (f_flush),
      .f_gnt     (f_gnt),
      .f_rvalid  (f_rvalid),
      .f_rdata   (f_rdata),
      .f_exc     (f_exc),
      .l_req     (l_req),
      .l_addr    (l_addr),
      .l_wdata   (l_wdata),
      .l_gnt     (l_gnt),
      .l_err     (l_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM: read data appears the cycle after a read enable.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge and let the combinational outputs settle.
   task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic ff,
                                input logic lr, input logic [31:0] la, input logic [31:0] lw);
      @(negedge clk);
      f_req   = fr;
      f_addr  = fa;
      f_flush = ff;
      l_req   = lr;
      l_addr  = la;
      l_wdata = lw;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   logic [31:0] badAddr [3];
   logic        expL [6];
   logic        expF [6];

   initial begin
      checkCount = 0;
      errorCount = 0;
      for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
      ram[0]    = 32'h3C01_0001;
      ram[1]    = 32'hAABB_CCDD;
      ram[2047] = 32'h0BAD_F00D;
      mem_rdata = 32'h0;

      reset_n = 1'b0;
      f_req   = 1'b1;
      f_addr  = 32'h3000;
      f_flush = 1'b0;
      l_req   = 1'b1;
      l_addr  = 32'h3000;
      l_wdata = 32'hFFFF_FFFF;
      #12;
      checkOutput("rst_f_gnt",    {31'b0, f_gnt},    32'h0);
      checkOutput("rst_l_gnt",    {31'b0, l_gnt},    32'h0);
      checkOutput("rst_mem_en",   {31'b0, mem_en},   32'h0);
      checkOutput("rst_f_rvalid", {31'b0, f_rvalid}, 32'h0);
      checkOutput("rst_f_rdata",  f_rdata,           32'h0);
      @(negedge clk);
      f_req = 1'b0;
      l_req = 1'b0;
      reset_n = 1'b1;

      // Legal fetch, one-cycle latency
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("t1_f_gnt",    {31'b0, f_gnt},  32'h1);
      checkOutput("t1_mem_en",   {31'b0, mem_en}, 32'h1);
      checkOutput("t1_mem_we",   {31'b0, mem_we}, 32'h0);
      checkOutput("t1_mem_addr", {20'b0, mem_addr}, 32'h0);
      checkOutput("t1_rvalid0",  {31'b0, f_rvalid}, 32'h0);
      idleCycle();
      checkOutput("t1_rvalid",   {31'b0, f_rvalid}, 32'h1);
      checkOutput("t1_rdata",    f_rdata, 32'h3C01_0001);
      checkOutput("t1_exc",      {27'b0, f_exc}, 32'h0);
      idleCycle();
      checkOutput("t1_rvalid_off", {31'b0, f_rvalid}, 32'h0);

      // Illegal fetch addresses: misaligned, above LIMIT, below BASE
      badAddr[0] = 32'h3002;
      badAddr[1] = 32'h5000;
      badAddr[2] = 32'h2FFC;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, badAddr[i], 1'b0, 1'b0, 32'h0, 32'h0);
         checkOutput("t2_f_gnt",  {31'b0, f_gnt},  32'h1);
         checkOutput("t2_mem_en", {31'b0, mem_en}, 32'h0);
         idleCycle();
         checkOutput("t2_rvalid", {31'b0, f_rvalid}, 32'h1);
         checkOutput("t2_rdata",  f_rdata, 32'h0);
         checkOutput("t2_exc",    {27'b0, f_exc}, 32'h4);
      end

      // Top-of-range legal fetch
      applyStimulus(1'b1, 32'h4FFC, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("lim_mem_en",   {31'b0, mem_en}, 32'h1);
      checkOutput("lim_mem_addr", {20'b0, mem_addr}, 32'd2047);
      idleCycle();
      checkOutput("lim_rdata", f_rdata, 32'h0BAD_F00D);

      // Loader write then fetch of the same location
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h4180, 32'h1234_5678);
      checkOutput("t4_l_gnt",     {31'b0, l_gnt},  32'h1);
      checkOutput("t4_l_err",     {31'b0, l_err},  32'h0);
      checkOutput("t4_mem_en",    {31'b0, mem_en}, 32'h1);
      checkOutput("t4_mem_we",    {31'b0, mem_we}, 32'h1);
      checkOutput("t4_mem_addr",  {20'b0, mem_addr}, 32'd1120);
      checkOutput("t4_mem_wdata", mem_wdata, 32'h1234_5678);
      checkOutput("t4_no_rvalid", {31'b0, f_rvalid}, 32'h0);
      applyStimulus(1'b1, 32'h4180, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("t4_f_mem_addr", {20'b0, mem_addr}, 32'd1120);
      idleCycle();
      checkOutput("t4_rdata", f_rdata, 32'h1234_5678);

      // Back-to-back fetches
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("b2b_rvalid",   {31'b0, f_rvalid}, 32'h1);
      checkOutput("b2b_rdata0",   f_rdata, 32'h3C01_0001);
      checkOutput("b2b_f_gnt",    {31'b0, f_gnt}, 32'h1);
      checkOutput("b2b_mem_addr", {20'b0, mem_addr}, 32'd1);
      idleCycle();
      checkOutput("b2b_rdata1",   f_rdata, 32'hAABB_CCDD);

      // Loader burst limit while fetch waits
      expL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      expF = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 32'h3000, 1'b0, 1'b1, 32'h3100, 32'h5555_0000 + i);
         checkOutput($sformatf("t3_l_gnt_%0d", i), {31'b0, l_gnt}, {31'b0, expL[i]});
         checkOutput($sformatf("t3_f_gnt_%0d", i), {31'b0, f_gnt}, {31'b0, expF[i]});
      end
      checkOutput("t3_rvalid", {31'b0, f_rvalid}, 32'h1);
      checkOutput("t3_rdata",  f_rdata, 32'h3C01_0001);
      idleCycle();

      // Flush kills the earlier fetch but not the one granted alongside it
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h3004, 1'b1, 1'b0, 32'h0, 32'h0);
      checkOutput("t5_flush_rvalid", {31'b0, f_rvalid}, 32'h0);
      checkOutput("t5_flush_rdata",  f_rdata, 32'h0);
      checkOutput("t5_f_gnt",        {31'b0, f_gnt}, 32'h1);
      idleCycle();
      checkOutput("t5_rvalid", {31'b0, f_rvalid}, 32'h1);
      checkOutput("t5_rdata",  f_rdata, 32'hAABB_CCDD);

      // Illegal loader address
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h4FFE, 32'hDEAD_BEEF);
      checkOutput("t6_l_gnt",  {31'b0, l_gnt},  32'h1);
      checkOutput("t6_l_err",  {31'b0, l_err},  32'h1);
      checkOutput("t6_mem_en", {31'b0, mem_en}, 32'h0);

      // Reset asserted while a read response is pending
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
      f_req   = 1'b0;
      reset_n = 1'b0;
      #1;
      checkOutput("t6_rst_rvalid", {31'b0, f_rvalid}, 32'h0);
      checkOutput("t6_rst_rdata",  f_rdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("t6_post_rvalid0", {31'b0, f_rvalid}, 32'h0);
      idleCycle();
      checkOutput("t6_post_rvalid1", {31'b0, f_rvalid}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
